pc_fetch_unit: RTL and testbench

Holds the architectural PC register and performs instruction fetch for the monocycle MIPS core. It sits directly downstream of the next-PC 3:1 select, which chooses between PC+4, branch target and jump target. It latches that selected next_pc on each instruction retire, fetches the instruction from instruction memory over a req/ack handshake, and presents a stable instruction to decode. It also returns pc_plus4 to the select stage as its in0 input.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_timeout_ctr.sv | 35 +++
 rtl/pc_fetch_unit.sv | 134 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the monocycle MIPS core.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [1:0]  ALIGN_MASK       = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Clear/increment wait counter; tc_c flags the last allowed cycle (TIMEOUT-1).
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus req/ack instruction fetch; holds the fetched word for decode
// until the core retires it, and halts in ERR on misalignment or fetch timeout.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             pc_advance,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misalign_err,
  output logic             timeout_err,
  output logic             halted
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic             mis_q, mis_d;
  logic             to_q, to_d;
  logic             halted_q, halted_d;
  logic             ctr_clr, ctr_inc, ctr_tc_c;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .inc   (ctr_inc),
    .tc_c  (ctr_tc_c)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    req_d    = req_q;
    mis_d    = mis_q;
    to_d     = to_q;
    halted_d = halted_q;
    ctr_clr  = 1'b0;
    ctr_inc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        // An ack on the final allowed cycle still beats the timeout
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          ctr_clr = 1'b1;
          state_d = HOLD;
        end else if (ctr_tc_c) begin
          to_d     = 1'b1;
          halted_d = 1'b1;
          req_d    = 1'b0;
          state_d  = ERR;
        end else begin
          ctr_inc = 1'b1;
        end
      end
      HOLD: begin
        if (pc_advance) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          if ((next_pc[1:0] & ALIGN_MASK) == 2'b00) begin
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            mis_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = ERR;
          end
        end
      end
      ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      mis_q    <= 1'b0;
      to_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
      mis_q    <= mis_d;
      to_q     <= to_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = valid_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + WIDTH'(INSTR_BYTES);
  assign misalign_err = mis_q;
  assign timeout_err  = to_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic, all against
// a transaction-level model of the fetch unit.
module tb_pc_fetch_unit;

  localparam int unsigned WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic        timeout_err;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(.WIDTH(WIDTH), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_pc      (next_pc),
    .pc_advance   (pc_advance),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Model: what the core has been promised, not how the RTL encodes it
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_mis, m_to, m_dead;
  logic        m_booting;   // first cycle after reset release
  logic        m_fetching;  // a request is outstanding
  int          m_unacked;   // request cycles already spent without ack

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic adv, input logic [31:0] npc,
                            input logic ack, input logic [31:0] rd);
    if (!r) begin
      m_pc = RESET_PC; m_instr = '0; m_valid = 0; m_mis = 0; m_to = 0; m_dead = 0;
      m_booting = 1; m_fetching = 0; m_unacked = 0;
    end else if (m_dead) begin
      // absorbing until reset
    end else if (m_booting) begin
      m_booting = 0; m_fetching = 1; m_unacked = 0;
    end else if (m_fetching) begin
      if (ack) begin
        m_instr = rd; m_valid = 1; m_fetching = 0;
      end else if (m_unacked + 1 >= int'(TIMEOUT)) begin
        m_to = 1; m_dead = 1; m_fetching = 0;
      end else begin
        m_unacked++;
      end
    end else if (adv) begin
      m_pc = npc; m_valid = 0;
      if (npc % 4 != 0) begin
        m_mis = 1; m_dead = 1;
      end else begin
        m_fetching = 1; m_unacked = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("imem_req",     32'(imem_req),     32'(m_fetching));
    chk("imem_addr",    imem_addr,         m_pc);
    chk("pc",           pc,                m_pc);
    chk("pc_plus4",     pc_plus4,          m_pc + 32'd4);
    chk("instr",        instr,             m_instr);
    chk("instr_valid",  32'(instr_valid),  32'(m_valid));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    chk("timeout_err",  32'(timeout_err),  32'(m_to));
    chk("halted",       32'(halted),       32'(m_dead));
  endtask

  task automatic cycle(input logic r, input logic adv, input logic [31:0] npc,
                       input logic ack, input logic [31:0] rd);
    @(negedge clk);
    rst_n = r; pc_advance = adv; next_pc = npc; imem_ack = ack; imem_rdata = rd;
    model_step(r, adv, npc, ack, rd);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] npc;
    logic        r, adv, ack;

    rst_n = 1'b0; pc_advance = 1'b0; next_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    m_pc = RESET_PC; m_instr = '0; m_valid = 0; m_mis = 0; m_to = 0; m_dead = 0;
    m_booting = 1; m_fetching = 0; m_unacked = 0;

    // Reset, boot, first fetch
    do_reset();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, RESET_PC);
    idle_cycles(1);
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h2008_0005);
    chk("first_instr", instr, 32'h2008_0005);
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc4", pc_plus4, 32'd4);

    // Sequential then branch advance; stray ack in HOLD ignored
    cycle(1'b1, 1'b1, 32'h4, 1'b0, 32'h0);
    chk("seq_addr", imem_addr, 32'h4);
    chk("seq_valid", 32'(instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk("hold_ack_ignored", instr, 32'h1111_1111);
    cycle(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("branch_addr", imem_addr, 32'h40);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222);

    // pc_advance during REQ ignored, then ack on the 16th request cycle
    cycle(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h1234, 1'b0, 32'h0);
    chk("req_adv_ignored", pc, 32'h80);
    idle_cycles(14);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h3333_3333);
    chk("late_ack_ok", 32'(timeout_err), 32'd0);
    chk("late_ack_valid", 32'(instr_valid), 32'd1);

    // Timeout after 16 unacked request cycles; ERR ignores inputs
    cycle(1'b1, 1'b1, 32'h84, 1'b0, 32'h0);
    idle_cycles(15);
    chk("pre_timeout", 32'(halted), 32'd0);
    idle_cycles(1);
    chk("timeout_err", 32'(timeout_err), 32'd1);
    chk("timeout_halt", 32'(halted), 32'd1);
    cycle(1'b1, 1'b1, 32'h100, 1'b1, 32'h4444_4444);
    chk("err_pc_frozen", pc, 32'h84);

    // PC wrap at the top of the address space
    do_reset();
    idle_cycles(1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h6666_6666);
    chk("wrap_pc4", pc_plus4, 32'h0);
    cycle(1'b1, 1'b1, pc_plus4, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h7777_7777);

    // Misaligned next_pc
    cycle(1'b1, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_pc", pc, 32'h102);
    chk("mis_req", 32'(imem_req), 32'd0);
    idle_cycles(2);

    // Reset mid-fetch, then a late ack
    do_reset();
    idle_cycles(1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h8888_8888);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_instr", instr, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h9999_9999);
    chk("midrst_late_ack", 32'(instr_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 59) != 0);
      adv = ($urandom_range(0, 1) == 1);
      ack = ($urandom_range(0, 2) == 0);
      npc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) npc = npc | 32'($urandom_range(1, 3));
      cycle(r, adv, npc, ack, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
